// File: rtl/ddr_preload_engine.sv
// Preloads a DDR region from a word-addressed table over Avalon-MM, packing table
// words into full-width beats, writing them in bursts, and optionally reading them back to count mismatches.
module ddr_preload_engine #(
    parameter int AMM_DATA_W = 256,
    parameter int AMM_ADDR_W = 25,
    parameter int WORD_W     = 32,
    parameter int NUM_WORDS  = 28,
    parameter int BURST_MAX  = 4,
    parameter int VERIFY     = 1
) (
    input  logic                    avalon_clk,
    input  logic                    avalon_reset,
    input  logic                    start,
    input  logic [AMM_ADDR_W-1:0]   base_addr,
    output logic [((NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1)-1:0] tbl_addr,
    input  logic [WORD_W-1:0]       tbl_data,
    output logic [AMM_ADDR_W-1:0]   amm_addr,
    output logic [AMM_DATA_W-1:0]   amm_writedata,
    output logic                    amm_write,
    output logic                    amm_read,
    output logic [AMM_DATA_W/8-1:0] amm_byteenable,
    output logic [6:0]              amm_burstcount,
    input  logic [AMM_DATA_W-1:0]   amm_readdata,
    input  logic                    amm_readdatavalid,
    input  logic                    amm_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             err_count,
    output logic [2:0]              state_dbg
);

    // Handshake: a request (amm_write or amm_read) and its address, data and
    // burstcount stay stable until a rising edge where amm_ready is 1.
    localparam int WPB    = AMM_DATA_W / WORD_W;
    localparam int NBEATS = (NUM_WORDS + WPB - 1) / WPB;
    localparam int TA_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BI_W   = $clog2(NBEATS + 1);
    localparam int FC_W   = $clog2(WPB + 1);
    localparam int WI_W   = $clog2(NBEATS * WPB + WPB + 1);
    localparam logic [WI_W-1:0] NUM_WORDS_W = WI_W'(NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE, FILL, WRITE, RD_FILL, RD_REQ, RD_WAIT, DONE
    } state_t;

    state_t                  state;
    logic [BI_W-1:0]         beat_idx;
    logic [FC_W-1:0]         fill_cnt;
    logic [WI_W-1:0]         word_idx;
    logic [AMM_DATA_W-1:0]   beat_buf;
    logic [6:0]              burst_left;
    logic [AMM_ADDR_W-1:0]   base_q;

    logic [WI_W-1:0]         word_inc;
    logic [WI_W-1:0]         lane_word;
    logic [WORD_W-1:0]       lane_val;
    logic [FC_W-1:0]         lane_sel;
    logic [AMM_DATA_W-1:0]   beat_next;
    logic [BI_W-1:0]         beat_inc;
    logic                    last_beat;
    int                      rem_beats;
    logic [6:0]              burst_len;
    logic [AMM_ADDR_W-1:0]   beat_addr;
    logic [WI_W-1:0]         next_wbase;

    assign state_dbg = state;

    // word_idx is the table word whose address is on tbl_addr this cycle; the
    // data arriving now belongs to the previous word (one cycle of table latency).
    always_comb begin
        word_inc   = word_idx + WI_W'(1);
        lane_word  = word_idx - WI_W'(1);
        lane_val   = (lane_word < NUM_WORDS_W) ? tbl_data : '0;
        lane_sel   = fill_cnt - FC_W'(1);
        beat_next  = beat_buf;
        if (fill_cnt != '0)
            beat_next[lane_sel*WORD_W +: WORD_W] = lane_val;
        beat_inc   = beat_idx + BI_W'(1);
        last_beat  = (beat_inc == BI_W'(NBEATS));
        rem_beats  = NBEATS - int'(beat_idx);
        burst_len  = 7'((rem_beats > BURST_MAX) ? BURST_MAX : rem_beats);
        beat_addr  = base_q + AMM_ADDR_W'(beat_idx);
        next_wbase = WI_W'(beat_inc) * WI_W'(WPB);
    end

    always_ff @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            state          <= IDLE;
            beat_idx       <= '0;
            fill_cnt       <= '0;
            word_idx       <= '0;
            beat_buf       <= '0;
            burst_left     <= '0;
            base_q         <= '0;
            tbl_addr       <= '0;
            amm_addr       <= '0;
            amm_writedata  <= '0;
            amm_write      <= 1'b0;
            amm_read       <= 1'b0;
            amm_byteenable <= '0;
            amm_burstcount <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_count      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base_q         <= base_addr;
                        beat_idx       <= '0;
                        fill_cnt       <= '0;
                        word_idx       <= '0;
                        tbl_addr       <= '0;
                        burst_left     <= '0;
                        error          <= 1'b0;
                        err_count      <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        amm_byteenable <= '1;
                        state          <= FILL;
                    end
                end

                FILL, RD_FILL: begin
                    fill_cnt <= fill_cnt + FC_W'(1);
                    word_idx <= word_inc;
                    if (word_inc < NUM_WORDS_W)
                        tbl_addr <= TA_W'(word_inc);
                    if (fill_cnt != '0)
                        beat_buf <= beat_next;
                    if (fill_cnt == FC_W'(WPB)) begin
                        if (state == FILL) begin
                            amm_write     <= 1'b1;
                            amm_writedata <= beat_next;
                            // Address and burstcount are only loaded on the first beat of a burst.
                            if (burst_left == '0) begin
                                amm_addr       <= beat_addr;
                                amm_burstcount <= burst_len;
                                burst_left     <= burst_len;
                            end
                            state <= WRITE;
                        end else begin
                            amm_read       <= 1'b1;
                            amm_addr       <= beat_addr;
                            amm_burstcount <= 7'd1;
                            state          <= RD_REQ;
                        end
                    end
                end

                WRITE: begin
                    if (amm_ready) begin
                        amm_write  <= 1'b0;
                        burst_left <= burst_left - 7'd1;
                        beat_idx   <= beat_inc;
                        if (!last_beat) begin
                            word_idx <= next_wbase;
                            tbl_addr <= TA_W'(next_wbase);
                            fill_cnt <= '0;
                            state    <= FILL;
                        end else if (VERIFY != 0) begin
                            beat_idx <= '0;
                            word_idx <= '0;
                            tbl_addr <= '0;
                            fill_cnt <= '0;
                            state    <= RD_FILL;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                RD_REQ: begin
                    if (amm_ready) begin
                        amm_read <= 1'b0;
                        state    <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (amm_readdatavalid) begin
                        if (amm_readdata != beat_buf) begin
                            error <= 1'b1;
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                        end
                        beat_idx <= beat_inc;
                        if (!last_beat) begin
                            word_idx <= next_wbase;
                            tbl_addr <= TA_W'(next_wbase);
                            fill_cnt <= '0;
                            state    <= RD_FILL;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_preload_engine.sv
// Bench for ddr_preload_engine: instance 0 uses defaults (verify on), instance 1 uses
// BURST_MAX=3 with verify off; a small Avalon slave and index-valued table serve both.
module tb_ddr_preload_engine;

    logic         avalon_clk;
    logic         avalon_reset;
    logic         start_s           [2];
    logic [24:0]  base_s            [2];
    logic [4:0]   tbl_addr_s        [2];
    logic [31:0]  tbl_data_s        [2];
    logic [24:0]  amm_addr_s        [2];
    logic [255:0] amm_writedata_s   [2];
    logic         amm_write_s       [2];
    logic         amm_read_s        [2];
    logic [31:0]  amm_byteenable_s  [2];
    logic [6:0]   amm_burstcount_s  [2];
    logic [255:0] amm_readdata_s    [2];
    logic         amm_readdatavalid_s [2];
    logic         amm_ready_s       [2];
    logic         busy_s            [2];
    logic         done_s            [2];
    logic         error_s           [2];
    logic [15:0]  err_count_s       [2];
    logic [2:0]   state_dbg_s       [2];

    // Clock/reset block
    initial avalon_clk = 1'b0;
    always #5 avalon_clk = ~avalon_clk;

    ddr_preload_engine #(.BURST_MAX(4), .VERIFY(1)) dut0 (
        .avalon_clk(avalon_clk), .avalon_reset(avalon_reset),
        .start(start_s[0]), .base_addr(base_s[0]),
        .tbl_addr(tbl_addr_s[0]), .tbl_data(tbl_data_s[0]),
        .amm_addr(amm_addr_s[0]), .amm_writedata(amm_writedata_s[0]),
        .amm_write(amm_write_s[0]), .amm_read(amm_read_s[0]),
        .amm_byteenable(amm_byteenable_s[0]), .amm_burstcount(amm_burstcount_s[0]),
        .amm_readdata(amm_readdata_s[0]), .amm_readdatavalid(amm_readdatavalid_s[0]),
        .amm_ready(amm_ready_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .error(error_s[0]), .err_count(err_count_s[0]), .state_dbg(state_dbg_s[0])
    );

    ddr_preload_engine #(.BURST_MAX(3), .VERIFY(0)) dut1 (
        .avalon_clk(avalon_clk), .avalon_reset(avalon_reset),
        .start(start_s[1]), .base_addr(base_s[1]),
        .tbl_addr(tbl_addr_s[1]), .tbl_data(tbl_data_s[1]),
        .amm_addr(amm_addr_s[1]), .amm_writedata(amm_writedata_s[1]),
        .amm_write(amm_write_s[1]), .amm_read(amm_read_s[1]),
        .amm_byteenable(amm_byteenable_s[1]), .amm_burstcount(amm_burstcount_s[1]),
        .amm_readdata(amm_readdata_s[1]), .amm_readdatavalid(amm_readdatavalid_s[1]),
        .amm_ready(amm_ready_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .error(error_s[1]), .err_count(err_count_s[1]), .state_dbg(state_dbg_s[1])
    );

    // Table + Avalon slave model with write/read logs
    logic [255:0] mem      [2][8];
    logic [24:0]  wl_addr  [2][64];
    logic [6:0]   wl_bc    [2][64];
    logic [255:0] wl_data  [2][64];
    logic [24:0]  rl_addr  [2][64];
    logic [24:0]  wcur     [2];
    int           wrem     [2];
    int           wcount   [2];
    int           rcount   [2];
    int           rises    [2];
    logic         done_d   [2];
    logic         corrupt  [2];
    int           viol;

    initial begin
        for (int i = 0; i < 2; i++) begin
            wcount[i] = 0; rcount[i] = 0; rises[i] = 0; wrem[i] = 0;
            done_d[i] = 1'b0; wcur[i] = '0;
        end
        viol = 0;
    end

    always @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            for (int i = 0; i < 2; i++) begin
                wrem[i] = 0;
                done_d[i] = 1'b0;
                tbl_data_s[i] <= '0;
                amm_readdatavalid_s[i] <= 1'b0;
                amm_readdata_s[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                tbl_data_s[i] <= 32'(tbl_addr_s[i]);
                amm_readdatavalid_s[i] <= 1'b0;
                if (amm_write_s[i] && amm_ready_s[i]) begin
                    if (wrem[i] == 0) begin
                        wcur[i] = amm_addr_s[i];
                        wrem[i] = int'(amm_burstcount_s[i]);
                    end
                    if (wcount[i] < 64) begin
                        wl_addr[i][wcount[i]] = amm_addr_s[i];
                        wl_bc[i][wcount[i]]   = amm_burstcount_s[i];
                        wl_data[i][wcount[i]] = amm_writedata_s[i];
                    end
                    mem[i][wcur[i][2:0]] = amm_writedata_s[i];
                    wcur[i] = wcur[i] + 25'd1;
                    wrem[i] = wrem[i] - 1;
                    wcount[i] = wcount[i] + 1;
                end
                if (amm_read_s[i] && amm_ready_s[i]) begin
                    if (rcount[i] < 64) rl_addr[i][rcount[i]] = amm_addr_s[i];
                    rcount[i] = rcount[i] + 1;
                    amm_readdata_s[i] <= mem[i][amm_addr_s[i][2:0]] ^
                        ((corrupt[i] && amm_addr_s[i] == 25'h102) ? 256'd1 : 256'd0);
                    amm_readdatavalid_s[i] <= 1'b1;
                end
                if (done_s[i] && !done_d[i]) rises[i] = rises[i] + 1;
                done_d[i] = done_s[i];
            end
        end
    end

    always @(negedge avalon_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (amm_write_s[i] && amm_read_s[i]) viol = viol + 1;
            if (amm_write_s[i] && amm_byteenable_s[i] != 32'hFFFF_FFFF) viol = viol + 1;
            if (amm_read_s[i] && amm_burstcount_s[i] != 7'd1) viol = viol + 1;
        end
    end

    // Scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out", name);
    endtask

    typedef struct packed {
        logic [0:0]   inst;
        logic [1:0]   beat;
        logic [24:0]  addr;
        logic [6:0]   bc;
        logic [255:0] data;
    } vec_t;

    vec_t vec [8];

    task automatic check_log(input int i, input int first, input string tag);
        for (int v = 0; v < 8; v++) begin
            if (int'(vec[v].inst) == i) begin
                int k;
                k = first + int'(vec[v].beat);
                chk($sformatf("%s i%0d beat%0d addr", tag, i, vec[v].beat), 256'(wl_addr[i][k]), 256'(vec[v].addr));
                chk($sformatf("%s i%0d beat%0d bc", tag, i, vec[v].beat), 256'(wl_bc[i][k]), 256'(vec[v].bc));
                chk($sformatf("%s i%0d beat%0d data", tag, i, vec[v].beat), wl_data[i][k], vec[v].data);
            end
        end
    endtask

    // Driver tasks
    task automatic start_pulse(input logic [1:0] mask, input logic [24:0] base);
        @(negedge avalon_clk);
        for (int i = 0; i < 2; i++) begin
            if (mask[i]) begin
                start_s[i] = 1'b1;
                base_s[i]  = base;
            end
        end
        @(negedge avalon_clk);
        for (int i = 0; i < 2; i++) start_s[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cycles);
        cycles = 0;
        while (!done_s[i] && cycles < 400) begin
            @(negedge avalon_clk);
            cycles++;
        end
        if (!done_s[i]) timeout($sformatf("wait done i%0d", i));
    endtask

    task automatic wait_write(input int i, input int n);
        int c;
        c = 0;
        while (!((wcount[i] == n) && amm_write_s[i]) && c < 400) begin
            @(negedge avalon_clk);
            c++;
        end
        if (c >= 400) timeout($sformatf("wait write i%0d beat%0d", i, n));
    endtask

    task automatic check_idle_outputs(input int i, input string tag);
        chk($sformatf("%s i%0d write/read", tag, i), {254'd0, amm_write_s[i], amm_read_s[i]}, 256'd0);
        chk($sformatf("%s i%0d busy/done/error", tag, i), {253'd0, busy_s[i], done_s[i], error_s[i]}, 256'd0);
        chk($sformatf("%s i%0d byteenable", tag, i), 256'(amm_byteenable_s[i]), 256'd0);
        chk($sformatf("%s i%0d addr/bc/tbl", tag, i),
            {219'd0, amm_addr_s[i], amm_burstcount_s[i], tbl_addr_s[i]}, 256'd0);
        chk($sformatf("%s i%0d writedata", tag, i), amm_writedata_s[i], 256'd0);
        chk($sformatf("%s i%0d err_count", tag, i), 256'(err_count_s[i]), 256'd0);
    endtask

    initial begin
        int cyc, ws0, ws1, rs0, r1;
        vec[0] = '{1'b0, 2'd0, 25'h100, 7'd4, 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000};
        vec[1] = '{1'b0, 2'd1, 25'h100, 7'd4, 256'h0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009_00000008};
        vec[2] = '{1'b0, 2'd2, 25'h100, 7'd4, 256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010};
        vec[3] = '{1'b0, 2'd3, 25'h100, 7'd4, 256'h00000000_00000000_00000000_00000000_0000001b_0000001a_00000019_00000018};
        vec[4] = '{1'b1, 2'd0, 25'h100, 7'd3, vec[0].data};
        vec[5] = '{1'b1, 2'd1, 25'h100, 7'd3, vec[1].data};
        vec[6] = '{1'b1, 2'd2, 25'h100, 7'd3, vec[2].data};
        vec[7] = '{1'b1, 2'd3, 25'h103, 7'd1, vec[3].data};

        avalon_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; base_s[i] = 25'h100; amm_ready_s[i] = 1'b1; corrupt[i] = 1'b0;
        end
        repeat (3) @(negedge avalon_clk);
        avalon_reset = 1'b0;
        @(negedge avalon_clk);
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset");

        // Basic load on both instances; instance 1 also checks completion latency.
        ws0 = wcount[0]; ws1 = wcount[1]; rs0 = rcount[0];
        start_pulse(2'b11, 25'h100);
        chk("busy after start i0", 256'(busy_s[0]), 256'd1);
        wait_done(1, cyc);
        n_checks++;
        if (cyc >= 38 && cyc <= 42) n_pass++;
        else $display("FAIL done latency i1: got %0d cycles expected 40+-2", cyc);
        wait_done(0, cyc);
        chk("basic i0 write beats", 256'(wcount[0] - ws0), 256'd4);
        chk("basic i1 write beats", 256'(wcount[1] - ws1), 256'd4);
        check_log(0, ws0, "basic");
        check_log(1, ws1, "basic");
        chk("basic i0 read beats", 256'(rcount[0] - rs0), 256'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("basic i0 read addr%0d", k), 256'(rl_addr[0][rs0 + k]), 256'(25'h100 + 25'(k)));
        chk("basic i0 done/busy/error", {253'd0, done_s[0], busy_s[0], error_s[0]}, 256'b100);
        chk("basic i0 err_count", 256'(err_count_s[0]), 256'd0);
        chk("basic i1 done/busy", {254'd0, done_s[1], busy_s[1]}, 256'b10);

        // Five-cycle stall on write beat 2.
        ws0 = wcount[0];
        start_pulse(2'b01, 25'h100);
        wait_write(0, ws0 + 2);
        amm_ready_s[0] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge avalon_clk);
            chk($sformatf("stall%0d write", s), 256'(amm_write_s[0]), 256'd1);
            chk($sformatf("stall%0d data", s), amm_writedata_s[0], vec[2].data);
            chk($sformatf("stall%0d addr/bc", s), {224'd0, amm_addr_s[0], amm_burstcount_s[0]}, {224'd0, 25'h100, 7'd4});
        end
        amm_ready_s[0] = 1'b1;
        wait_done(0, cyc);
        chk("stall write beats", 256'(wcount[0] - ws0), 256'd4);
        check_log(0, ws0, "stall");
        chk("stall err_count", 256'(err_count_s[0]), 256'd0);

        // Corrupted read-back of beat 2, then a clean run clears the error state.
        corrupt[0] = 1'b1;
        start_pulse(2'b01, 25'h100);
        wait_done(0, cyc);
        corrupt[0] = 1'b0;
        chk("corrupt err_count", 256'(err_count_s[0]), 256'd1);
        chk("corrupt error/done", {254'd0, error_s[0], done_s[0]}, 256'b11);
        start_pulse(2'b01, 25'h100);
        chk("restart clears error/done, sets busy", {253'd0, error_s[0], done_s[0], busy_s[0]}, 256'b001);
        chk("restart clears err_count", 256'(err_count_s[0]), 256'd0);
        wait_done(0, cyc);
        chk("clean rerun err_count", 256'(err_count_s[0]), 256'd0);

        // start pulsed while a write beat is pending must be ignored.
        ws1 = wcount[1]; r1 = rises[1];
        start_pulse(2'b10, 25'h100);
        wait_write(1, ws1 + 1);
        start_pulse(2'b10, 25'h1F0);
        wait_done(1, cyc);
        repeat (60) @(negedge avalon_clk);
        chk("midwrite beats", 256'(wcount[1] - ws1), 256'd4);
        chk("midwrite done rises", 256'(rises[1] - r1), 256'd1);
        chk("midwrite busy/done", {254'd0, busy_s[1], done_s[1]}, 256'b01);
        check_log(1, ws1, "midwrite");

        // Reset during burst beat 1, then a full reload.
        ws0 = wcount[0];
        start_pulse(2'b01, 25'h100);
        wait_write(0, ws0 + 1);
        avalon_reset = 1'b1;
        #1;
        check_idle_outputs(0, "midreset");
        @(negedge avalon_clk);
        avalon_reset = 1'b0;
        @(negedge avalon_clk);
        ws0 = wcount[0]; ws1 = wcount[1]; rs0 = rcount[0];
        start_pulse(2'b11, 25'h100);
        wait_done(1, cyc);
        wait_done(0, cyc);
        chk("reload i0 write beats", 256'(wcount[0] - ws0), 256'd4);
        check_log(0, ws0, "reload");
        check_log(1, ws1, "reload");
        chk("reload i0 read beats", 256'(rcount[0] - rs0), 256'd4);
        chk("reload i0 error/err_count", {239'd0, error_s[0], err_count_s[0]}, 256'd0);

        chk("protocol violations", 256'(viol), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
